adder_checker: RTL and testbench
================================

ADDER_CHECKER -- requirements
Module: adder_checker

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits.
REQ-002 Parameter CNT_W, default 16, width of the check and error counters.
REQ-003 Parameter TARGET, default 1000, number of samples checked per run; legal range 1 to 2^CNT_W-1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  pulse that begins a run; honoured only in IDLE or DONE.
REQ-007 in_valid  input  1  operand0/operand1/result sample valid.
REQ-008 in_ready  output  1  checker accepts a sample this cycle.
REQ-009 operand0  input  WIDTH  first adder operand.
REQ-010 operand1  input  WIDTH  second adder operand.
REQ-011 result  input  WIDTH  adder output under test.
REQ-012 busy  output  1  high in RUN and DRAIN.
REQ-013 done  output  1  high in DONE.
REQ-014 pass  output  1  high in DONE when err_count is 0; low otherwise.
REQ-015 chk_count  output  CNT_W  samples compared this run.
REQ-016 err_count  output  CNT_W  mismatching samples this run.
REQ-017 first_err_valid  output  1  a mismatch has been captured this run.
REQ-018 first_err_op0, first_err_op1, first_err_result  output  WIDTH each  operands and result of the first mismatch.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE: start=1 -> RUN; counters, accept count and first_err_* cleared on the same edge.
REQ-021 RUN: in_ready = 1 while the accept count is below TARGET; 0 otherwise.
REQ-022 Handshake: a sample is accepted on an edge where in_valid and in_ready are both 1; in_valid without in_ready has no effect.
REQ-023 in_valid may drop between samples; gaps of any length are legal.
REQ-024 Stage 1: accepted sample is registered on the accept edge.
REQ-025 Stage 2: expected = (operand0 + operand1) mod 2^WIDTH, with the carry out discarded; it is compared to the registered result on the next edge.
REQ-026 Latency: chk_count, err_count and first_err_* reflect a sample exactly one edge after its accept edge.
REQ-027 Each compare increments chk_count; each mismatch also increments err_count.
REQ-028 Both counters saturate at 2^CNT_W-1 and do not wrap.
REQ-029 First mismatch of a run loads first_err_* and sets first_err_valid; later mismatches leave them unchanged.
REQ-030 RUN -> DRAIN on the edge accepting sample TARGET; in_ready is 0 from that edge.
REQ-031 DRAIN lasts one cycle while the stage-2 compare completes, then -> DONE.
REQ-032 DONE holds all results stable; start=1 -> RUN with clear as in REQ-020.
REQ-033 start in RUN or DRAIN is ignored.
REQ-034 Simultaneous start and in_valid in IDLE/DONE: the sample is not accepted, because in_ready is 0 outside RUN.
REQ-035 TARGET=1: RUN accepts one sample, then DRAIN, then DONE.

Reset
REQ-036 rst=1 forces IDLE immediately regardless of clock, including mid-RUN or mid-DRAIN; in-flight samples are discarded.
REQ-037 Reset values: in_ready=0, busy=0, done=0, pass=0, chk_count=0, err_count=0, first_err_valid=0, first_err_op0/op1/result=0, stage registers cleared.

Verification
REQ-038 TARGET=4, start, then four correct samples (3+4=7, 100+27=127, 0+0=0, 127+127=254) back-to-back -> done=1, pass=1, chk_count=4, err_count=0, first_err_valid=0.
REQ-039 TARGET=3, samples (1+1=2), (5+6=12), (200+100=44) -> 200+100 wraps to 44 and is correct; err_count=1, pass=0, first_err = 5/6/12.
REQ-040 Random operands {$random}%128 with in_valid toggling every other cycle, TARGET=1000, result forced wrong on samples 10 and 20 -> err_count=2, first_err holds sample 10, chk_count=1000, in_ready stays 0 after sample 1000.
REQ-041 rst asserted mid-RUN after 5 of 10 samples -> outputs return to reset values within the same cycle; a new start gives chk_count counting from 0.
REQ-042 CNT_W=2, TARGET=3, all samples wrong -> err_count=3; with TARGET=3 and CNT_W=2, err_count reaches 3 and saturates with no wrap.
REQ-043 start pulsed during RUN -> no clear and counts continue; start pulsed in DONE -> clear and new run begins.

Source files
------------

// File: rtl/adder_checker.sv
// Streaming adder checker: accepts operand/result samples, recomputes the sum
// one stage later and keeps compare/error counts plus the first failing sample.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | accepting samples until TARGET have been taken
// DRAIN | last accepted sample is in the compare stage
// DONE  | results held stable until the next start
module adder_checker #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 16,
  parameter int TARGET = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand0,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_op0,
  output logic [WIDTH-1:0] first_err_op1,
  output logic [WIDTH-1:0] first_err_result
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] TGT     = CNT_W'(TARGET);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remain;
  logic             accept;
  logic             clear;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_op0, s1_op1, s1_res;
  logic [WIDTH-1:0] s2_sum;
  logic             s2_mismatch;

  // remain counts down the samples still to be accepted in this run
  assign in_ready = (state == RUN) && (remain != '0);
  assign accept   = in_valid && in_ready;
  assign pass     = done && (err_count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear     = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (accept && (remain == CNT_ONE)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          clear     = 1'b1;
          state_nxt = RUN;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         remain <= '0;
    else if (clear)  remain <= TGT;
    else if (accept) remain <= remain - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op0   <= '0;
      s1_op1   <= '0;
      s1_res   <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_op0   <= '0;
      s1_op1   <= '0;
      s1_res   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op0 <= operand0;
        s1_op1 <= operand1;
        s1_res <= result;
      end
    end
  end

  // carry out is intentionally dropped: the DUT under test is a WIDTH-bit adder
  assign s2_sum      = s1_op0 + s1_op1;
  assign s2_mismatch = s1_valid && (s2_sum != s1_res);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_count        <= '0;
      err_count        <= '0;
      first_err_valid  <= 1'b0;
      first_err_op0    <= '0;
      first_err_op1    <= '0;
      first_err_result <= '0;
    end else if (clear) begin
      chk_count        <= '0;
      err_count        <= '0;
      first_err_valid  <= 1'b0;
      first_err_op0    <= '0;
      first_err_op1    <= '0;
      first_err_result <= '0;
    end else if (s1_valid) begin
      if (chk_count != '1) chk_count <= chk_count + CNT_ONE;
      if (s2_mismatch) begin
        if (err_count != '1) err_count <= err_count + CNT_ONE;
        if (!first_err_valid) begin
          first_err_valid  <= 1'b1;
          first_err_op0    <= s1_op0;
          first_err_op1    <= s1_op1;
          first_err_result <= s1_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_checker.sv
// Scoreboard bench for adder_checker: four instances with different TARGET/CNT_W,
// a sum-based reference model feeding an expected-result queue, and a monitor.
module tb_adder_checker;

  localparam int NI = 4;
  localparam int TGT_T [NI]  = '{1000, 4, 3, 1};
  localparam int CMAX_T [NI] = '{65535, 65535, 3, 65535};

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [7:0] op0, op1, res;
  logic [NI-1:0] start_v;
  logic [NI-1:0] rdy, bsy, dn, ps, fv;
  logic [NI-1:0][7:0] f0_a, f1_a, fr_a;
  logic [15:0] chk0, err0, chk1, err1, chk3, err3;
  logic [1:0]  chk2, err2;

  always #5 clk = ~clk;

  adder_checker #(.WIDTH(8), .CNT_W(16), .TARGET(1000)) u_big (
    .clk(clk), .rst(rst), .start(start_v[0]), .in_valid(in_valid), .in_ready(rdy[0]),
    .operand0(op0), .operand1(op1), .result(res), .busy(bsy[0]), .done(dn[0]), .pass(ps[0]),
    .chk_count(chk0), .err_count(err0), .first_err_valid(fv[0]),
    .first_err_op0(f0_a[0]), .first_err_op1(f1_a[0]), .first_err_result(fr_a[0]));

  adder_checker #(.WIDTH(8), .CNT_W(16), .TARGET(4)) u_t4 (
    .clk(clk), .rst(rst), .start(start_v[1]), .in_valid(in_valid), .in_ready(rdy[1]),
    .operand0(op0), .operand1(op1), .result(res), .busy(bsy[1]), .done(dn[1]), .pass(ps[1]),
    .chk_count(chk1), .err_count(err1), .first_err_valid(fv[1]),
    .first_err_op0(f0_a[1]), .first_err_op1(f1_a[1]), .first_err_result(fr_a[1]));

  adder_checker #(.WIDTH(8), .CNT_W(2), .TARGET(3)) u_t3 (
    .clk(clk), .rst(rst), .start(start_v[2]), .in_valid(in_valid), .in_ready(rdy[2]),
    .operand0(op0), .operand1(op1), .result(res), .busy(bsy[2]), .done(dn[2]), .pass(ps[2]),
    .chk_count(chk2), .err_count(err2), .first_err_valid(fv[2]),
    .first_err_op0(f0_a[2]), .first_err_op1(f1_a[2]), .first_err_result(fr_a[2]));

  adder_checker #(.WIDTH(8), .CNT_W(16), .TARGET(1)) u_t1 (
    .clk(clk), .rst(rst), .start(start_v[3]), .in_valid(in_valid), .in_ready(rdy[3]),
    .operand0(op0), .operand1(op1), .result(res), .busy(bsy[3]), .done(dn[3]), .pass(ps[3]),
    .chk_count(chk3), .err_count(err3), .first_err_valid(fv[3]),
    .first_err_op0(f0_a[3]), .first_err_op1(f1_a[3]), .first_err_result(fr_a[3]));

  typedef struct packed {
    logic ready, busy, done, pass, fev;
    logic [15:0] chk, err;
    logic [7:0] f0, f1, fr;
  } obs_t;

  typedef struct {
    int chk, err, fev, f0, f1, fr, due;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int prev_chk[NI];

  // reference model of the active run
  int m_inst, m_target, m_cmax, m_acc, m_chk, m_err, m_f0, m_f1, m_fr;
  bit m_active = 1'b0;
  bit m_fev;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t observe(int i);
    obs_t o;
    o.ready = rdy[i]; o.busy = bsy[i]; o.done = dn[i]; o.pass = ps[i]; o.fev = fv[i];
    o.f0 = f0_a[i]; o.f1 = f1_a[i]; o.fr = fr_a[i];
    case (i)
      0: begin o.chk = chk0; o.err = err0; end
      1: begin o.chk = chk1; o.err = err1; end
      2: begin o.chk = {14'd0, chk2}; o.err = {14'd0, err2}; end
      default: begin o.chk = chk3; o.err = err3; end
    endcase
    return o;
  endfunction

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: each rise of chk_count presents one compared sample
  always @(negedge clk) begin
    obs_t o;
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      o = observe(i);
      if (rst) prev_chk[i] = 0;
      else if (int'(o.chk) > prev_chk[i]) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: inst %0d chk=%0d with no expected entry", i, o.chk);
        end else begin
          e = sb_q.pop_front();
          check("sb_chk", int'(o.chk), e.chk);
          check("sb_err", int'(o.err), e.err);
          check("sb_fev", int'(o.fev), e.fev);
          check("sb_f0", int'(o.f0), e.f0);
          check("sb_f1", int'(o.f1), e.f1);
          check("sb_fr", int'(o.fr), e.fr);
          check("sb_latency", cyc, e.due);
        end
        prev_chk[i] = int'(o.chk);
      end else if (int'(o.chk) < prev_chk[i]) prev_chk[i] = int'(o.chk);
    end
  end

  task automatic model_clear(int sel);
    m_inst = sel; m_target = TGT_T[sel]; m_cmax = CMAX_T[sel];
    m_acc = 0; m_chk = 0; m_err = 0; m_fev = 1'b0;
    m_f0 = 0; m_f1 = 0; m_fr = 0; m_active = 1'b1;
  endtask

  task automatic model_accept(int a, int b, int r);
    exp_t e;
    m_acc++;
    if (m_chk < m_cmax) m_chk++;
    if (((a + b) % 256) != r) begin
      if (m_err < m_cmax) m_err++;
      if (!m_fev) begin m_fev = 1'b1; m_f0 = a; m_f1 = b; m_fr = r; end
    end
    e.chk = m_chk; e.err = m_err; e.fev = int'(m_fev);
    e.f0 = m_f0; e.f1 = m_f1; e.fr = m_fr; e.due = cyc + 1;
    sb_q.push_back(e);
    if (m_acc == m_target) m_active = 1'b0;
  endtask

  task automatic pulse_start(int sel);
    @(negedge clk);
    start_v[sel] = 1'b1;
    @(posedge clk);
    #1;
    start_v = '0;
    if (!m_active) model_clear(sel);
  endtask

  task automatic send(int sel, int a, int b, int r);
    obs_t o;
    bit exp_rdy;
    int av, bv, rv;
    av = a; bv = b; rv = r;
    @(negedge clk);
    op0 = av[7:0]; op1 = bv[7:0]; res = rv[7:0]; in_valid = 1'b1;
    #1;
    o = observe(sel);
    exp_rdy = m_active && (m_inst == sel) && (m_acc < m_target);
    check("in_ready", int'(o.ready), int'(exp_rdy));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (exp_rdy) model_accept(a, b, r);
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(int i);
    obs_t o;
    o = observe(i);
    check("rst_ready", int'(o.ready), 0);
    check("rst_busy", int'(o.busy), 0);
    check("rst_done", int'(o.done), 0);
    check("rst_pass", int'(o.pass), 0);
    check("rst_chk", int'(o.chk), 0);
    check("rst_err", int'(o.err), 0);
    check("rst_fev", int'(o.fev), 0);
    check("rst_first", int'({o.f0, o.f1, o.fr}), 0);
  endtask

  task automatic check_final(int sel);
    obs_t o;
    o = observe(sel);
    check("fin_busy", int'(o.busy), 0);
    check("fin_done", int'(o.done), 1);
    check("fin_ready", int'(o.ready), 0);
    check("fin_pass", int'(o.pass), int'(m_err == 0));
    check("fin_chk", int'(o.chk), m_chk);
    check("fin_err", int'(o.err), m_err);
    check("fin_fev", int'(o.fev), int'(m_fev));
    check("fin_f0", int'(o.f0), m_f0);
    check("fin_f1", int'(o.f1), m_f1);
    check("fin_fr", int'(o.fr), m_fr);
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) check_reset_vals(i);
    sb_q.delete();
    m_active = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int a, b, a10, b10, r10;
    rst = 1'b1; in_valid = 1'b0; start_v = '0; op0 = '0; op1 = '0; res = '0;
    a10 = 0; b10 = 0; r10 = 0;
    #12;
    for (int i = 0; i < NI; i++) check_reset_vals(i);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // four correct back-to-back samples
    pulse_start(1);
    send(1, 3, 4, 7); send(1, 100, 27, 127); send(1, 0, 0, 0); send(1, 127, 127, 254);
    idle(3);
    check_final(1);
    o = observe(1);
    check("t4_chk", int'(o.chk), 4);
    check("t4_pass", int'(o.pass), 1);

    // start in DONE clears; start in RUN is ignored
    pulse_start(1);
    o = observe(1);
    check("restart_chk", int'(o.chk), 0);
    check("restart_done", int'(o.done), 0);
    check("restart_busy", int'(o.busy), 1);
    send(1, 10, 20, 30); send(1, 50, 60, 111);
    pulse_start(1);
    idle(1);
    o = observe(1);
    check("run_start_ignored_chk", int'(o.chk), 2);
    check("run_start_ignored_err", int'(o.err), 1);
    send(1, 1, 2, 3); send(1, 250, 10, 4);
    idle(3);
    check_final(1);

    // wrap of 200+100 is correct; one real error
    pulse_start(2);
    send(2, 1, 1, 2); send(2, 5, 6, 12); send(2, 200, 100, 44);
    idle(3);
    check_final(2);
    o = observe(2);
    check("t3_err", int'(o.err), 1);
    check("t3_pass", int'(o.pass), 0);
    check("t3_first", int'({o.f0, o.f1, o.fr}), int'({8'd5, 8'd6, 8'd12}));

    // every sample wrong with 2-bit counters
    pulse_start(2);
    for (int k = 0; k < 3; k++) begin
      a = int'($urandom % 256); b = int'($urandom % 256);
      send(2, a, b, (a + b + 1) % 256);
    end
    idle(3);
    check_final(2);
    o = observe(2);
    check("sat_err", int'(o.err), 3);

    // start with simultaneous in_valid: sample not taken
    @(negedge clk);
    start_v[3] = 1'b1; in_valid = 1'b1; op0 = 8'd9; op1 = 8'd9; res = 8'd18;
    @(posedge clk);
    #1;
    start_v = '0; in_valid = 1'b0;
    model_clear(3);
    idle(2);
    o = observe(3);
    check("start_valid_chk", int'(o.chk), 0);
    send(3, 10, 20, 30);
    o = observe(3);
    check("t1_drain_busy", int'(o.busy), 1);
    check("t1_drain_done", int'(o.done), 0);
    check("t1_drain_ready", int'(o.ready), 0);
    idle(1);
    o = observe(3);
    check("t1_done", int'(o.done), 1);
    idle(2);
    check_final(3);

    // async reset mid-run, fifth sample in flight
    pulse_start(0);
    for (int k = 0; k < 5; k++) begin
      a = int'($urandom % 128); b = int'($urandom % 128);
      send(0, a, b, a + b);
    end
    async_reset();
    pulse_start(0);
    for (int k = 0; k < 3; k++) begin
      a = int'($urandom % 128); b = int'($urandom % 128);
      send(0, a, b, a + b);
    end
    idle(2);
    o = observe(0);
    check("post_rst_chk", int'(o.chk), 3);
    async_reset();

    // long random run, errors on samples 10 and 20
    pulse_start(0);
    for (int k = 1; k <= 1000; k++) begin
      a = int'($urandom % 128); b = int'($urandom % 128);
      if (k == 10) begin a10 = a; b10 = b; r10 = a + b + 1; end
      send(0, a, b, (k == 10 || k == 20) ? a + b + 1 : a + b);
      idle(1);
    end
    send(0, 1, 2, 3);
    idle(3);
    check_final(0);
    o = observe(0);
    check("big_chk", int'(o.chk), 1000);
    check("big_err", int'(o.err), 2);
    check("big_first", int'({o.f0, o.f1, o.fr}), int'({a10[7:0], b10[7:0], r10[7:0]}));
    check("big_ready_after", int'(o.ready), 0);

    idle(2);
    check("sb_drain", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
